// File: rtl/instr_fetch_responder_pkg.sv
// fetch_pkg: shared FSM states, NOP encoding and timeout counter width for the fetch responder
package fetch_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10} fetch_state_e;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int TMO_W = 8;
endpackage

// File: rtl/instr_fetch_responder_reuse_buffer.sv
// fetch_reuse_buffer: single-entry {tag_valid, tag_pc, word} store for 1-cycle re-delivery (FETCH_REUSE_EN)
module fetch_reuse_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill,
    input  logic        clear,
    input  logic [29:0] fill_pc,
    input  logic [31:0] fill_word,
    input  logic [29:0] pc,
    output logic        hit,
    output logic [31:0] word
);
    logic        tag_valid;
    logic [29:0] tag_pc;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tag_valid <= 1'b0;
        end else if (fill) begin
            tag_valid <= 1'b1;
            tag_pc    <= fill_pc;
            word      <= fill_word;
        end
    end
    assign hit = tag_valid && (pc == tag_pc);
endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: ready/valid instruction fetch owning clk_enable; FETCH_REUSE_EN adds a one-entry reuse buffer
module instr_fetch_responder
    import fetch_pkg::*;
#(
    parameter int          BUS_TIMEOUT = 255,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] pc,
    input  logic        mem_in_use,
    output logic        ibus_req_valid,
    output logic [29:0] ibus_req_addr,
    input  logic        ibus_req_ready,
    input  logic        ibus_resp_valid,
    input  logic [31:0] ibus_resp_data,
    output logic        clk_enable,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic        fetch_fault
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);
    fetch_state_e     state, state_n;
    logic [29:0]      req_addr_q;
    logic [TMO_W-1:0] cnt;
    logic [31:0]      instr_n;
    logic             valid_n, fault_set, reuse_hit, timeout;
    logic [31:0]      reuse_word;
`ifdef FETCH_REUSE_EN
    fetch_reuse_buffer u_reuse (
        .clk       (clk),
        .rst       (rst),
        .fill      (state == WAIT && ibus_resp_valid),
        .clear     (fault_set),
        .fill_pc   (req_addr_q),
        .fill_word (ibus_resp_data),
        .pc        (pc),
        .hit       (reuse_hit),
        .word      (reuse_word)
    );
`else
    assign reuse_hit  = 1'b0;
    assign reuse_word = NOP_WORD;
`endif
    assign timeout = (BUS_TIMEOUT != 0) && (cnt == TMO_LAST);
    always_comb begin
        state_n        = state;
        ibus_req_valid = 1'b0;
        ibus_req_addr  = req_addr_q;
        clk_enable     = 1'b0;
        instr_n        = instruction;
        valid_n        = instruction_valid;
        fault_set      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_in_use || reuse_hit) begin
                    clk_enable = 1'b1;
                    instr_n    = mem_in_use ? NOP_WORD : reuse_word;
                    valid_n    = !mem_in_use;
                end else begin
                    ibus_req_valid = 1'b1;
                    ibus_req_addr  = pc;
                    state_n        = ibus_req_ready ? WAIT : REQ;
                end
            end
            REQ: begin
                ibus_req_valid = 1'b1;
                state_n        = ibus_req_ready ? WAIT : REQ;
            end
            WAIT: begin
                if (ibus_resp_valid || timeout) begin
                    clk_enable = 1'b1;
                    instr_n    = ibus_resp_valid ? ibus_resp_data : NOP_WORD;
                    valid_n    = ibus_resp_valid;
                    fault_set  = !ibus_resp_valid;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            ibus_req_valid = 1'b0;
            clk_enable     = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            req_addr_q        <= '0;
            cnt               <= '0;
            instruction       <= NOP_WORD;
            instruction_valid <= 1'b0;
            fetch_fault       <= 1'b0;
        end else begin
            state       <= state_n;
            req_addr_q  <= (state == IDLE) ? pc : req_addr_q;
            cnt         <= (state != WAIT) ? '0 : (cnt == '1 ? cnt : cnt + 1'b1);
            fetch_fault <= fetch_fault | fault_set;
            if (clk_enable) begin
                instruction       <= instr_n;
                instruction_valid <= valid_n;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb_instr_fetch_responder: table-driven directed vectors for instr_fetch_responder with BUS_TIMEOUT=4
module tb_instr_fetch_responder;
    localparam logic [31:0] NOP = 32'h00000013;
    typedef struct {
        logic        rst;
        logic [29:0] pc;
        logic        miu, rdy, rv;
        logic [31:0] rd;
        logic        ce, rqv;
        logic [29:0] addr;
        logic [31:0] ins;
        logic        iv, flt, chk;
    } vec_t;
    logic        clk = 1'b0, rst = 1'b1, mem_in_use = 1'b0;
    logic [29:0] pc = '0;
    logic        ibus_req_valid, ibus_req_ready = 1'b0, ibus_resp_valid = 1'b0;
    logic [29:0] ibus_req_addr;
    logic [31:0] ibus_resp_data = '0, instruction;
    logic        clk_enable, instruction_valid, fetch_fault;
    int total = 0, bad = 0, row = 0;
    vec_t tbl[$];
    instr_fetch_responder #(.BUS_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .mem_in_use        (mem_in_use),
        .ibus_req_valid    (ibus_req_valid),
        .ibus_req_addr     (ibus_req_addr),
        .ibus_req_ready    (ibus_req_ready),
        .ibus_resp_valid   (ibus_resp_valid),
        .ibus_resp_data    (ibus_resp_data),
        .clk_enable        (clk_enable),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .fetch_fault       (fetch_fault)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(logic r, logic [29:0] p, logic m, logic rdy, logic rv, logic [31:0] rd,
                                logic ce, logic rqv, logic [29:0] a, logic [31:0] ins, logic iv, logic flt, logic chk);
        vec_t v;
        v.rst = r; v.pc = p; v.miu = m; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.ce = ce; v.rqv = rqv; v.addr = a; v.ins = ins; v.iv = iv; v.flt = flt; v.chk = chk;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, row, act, exp);
        end
    endtask
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; pc = v.pc; mem_in_use = v.miu;
        ibus_req_ready = v.rdy; ibus_resp_valid = v.rv; ibus_resp_data = v.rd;
        #1;
        chk("clk_enable", {31'b0, clk_enable}, {31'b0, v.ce});
        chk("req_valid", {31'b0, ibus_req_valid}, {31'b0, v.rqv});
        if (v.rqv) chk("req_addr", {2'b0, ibus_req_addr}, {2'b0, v.addr});
        if (v.chk) begin
            chk("instruction", instruction, v.ins);
            chk("instr_valid", {31'b0, instruction_valid}, {31'b0, v.iv});
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, v.flt});
        end
        row++;
    endtask
    initial begin
        tbl.push_back(mk(1, 'h00, 0, 0, 1, 'h0,        0, 0, 'h00, NOP,        0, 0, 0));
        tbl.push_back(mk(1, 'h00, 0, 0, 1, 'h0,        0, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(1, 'h00, 0, 0, 1, 'h0,        0, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h10, 0, 1, 0, 'h0,        0, 1, 'h10, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h10, 0, 0, 1, 'h00500093, 1, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h11, 0, 1, 0, 'h0,        0, 1, 'h11, 'h00500093, 1, 0, 1));
        tbl.push_back(mk(0, 'h11, 0, 0, 1, 'h00100113, 1, 0, 'h00, 'h00500093, 1, 0, 1));
        tbl.push_back(mk(0, 'h10, 0, 0, 0, 'h0,        0, 1, 'h10, 'h00100113, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 0, 'h0,        0, 1, 'h10, 'h00100113, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 1, 0, 0, 'h0,        0, 1, 'h10, 'h00100113, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 1, 0, 'h0,        0, 1, 'h10, 'h00100113, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 0, 'h0,        0, 0, 'h00, 'h00100113, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 1, 'hDEADBEEF, 1, 0, 'h00, 'h00100113, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 1, 0, 1, 'h12345678, 1, 0, 'h00, 'hDEADBEEF, 1, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 1, 0, 'h0,        0, 1, 'h20, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 0, 'h0,        0, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 0, 'h0,        0, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 0, 'h0,        0, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h20, 0, 0, 0, 'h0,        1, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h21, 0, 1, 0, 'h0,        0, 1, 'h21, NOP,        0, 1, 1));
        tbl.push_back(mk(0, 'h21, 0, 0, 1, 'hCAFE0013, 1, 0, 'h00, NOP,        0, 1, 1));
        tbl.push_back(mk(0, 'h22, 1, 0, 0, 'h0,        1, 0, 'h00, 'hCAFE0013, 1, 1, 1));
        tbl.push_back(mk(1, 'h22, 0, 0, 1, 'h0,        0, 0, 'h00, NOP,        0, 1, 1));
        tbl.push_back(mk(0, 'h22, 0, 1, 0, 'h0,        0, 1, 'h22, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h22, 0, 0, 1, 'h00000113, 1, 0, 'h00, NOP,        0, 0, 1));
        tbl.push_back(mk(0, 'h23, 1, 0, 0, 'h0,        1, 0, 'h00, 'h00000113, 1, 0, 1));
        foreach (tbl[i]) apply(tbl[i]);
        // Same pc fetched, bubbled, then re-presented: buffer hit if enabled, else back to the bus
        apply(mk(0, 'h40, 0, 1, 0, 'h0,        0, 1, 'h40, NOP,        0, 0, 1));
        apply(mk(0, 'h40, 0, 0, 1, 'h00A00513, 1, 0, 'h00, NOP,        0, 0, 1));
        apply(mk(0, 'h40, 1, 0, 0, 'h0,        1, 0, 'h00, 'h00A00513, 1, 0, 1));
`ifdef FETCH_REUSE_EN
        apply(mk(0, 'h40, 0, 1, 0, 'h0,        1, 0, 'h00, NOP,        0, 0, 1));
`else
        apply(mk(0, 'h40, 0, 1, 0, 'h0,        0, 1, 'h40, NOP,        0, 0, 1));
        apply(mk(0, 'h40, 0, 0, 1, 'h00A00513, 1, 0, 'h00, NOP,        0, 0, 1));
`endif
        apply(mk(1, 'h40, 0, 0, 0, 'h0,        0, 0, 'h00, 'h00A00513, 1, 0, 1));
        apply(mk(0, 'h40, 0, 1, 0, 'h0,        0, 1, 'h40, NOP,        0, 0, 1));
        apply(mk(0, 'h40, 0, 0, 1, 'h00A00513, 1, 0, 'h00, NOP,        0, 0, 1));
        apply(mk(0, 'h41, 1, 0, 0, 'h0,        1, 0, 'h00, 'h00A00513, 1, 0, 1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Serves the control unit's fetch side: takes the word PC the control unit presents, fetches the instruction over a ready/valid instruction bus, and returns it as a registered instruction word.
- Owns the pipeline-wide clk_enable. Every enabled cycle consumes exactly one fetched (or bubble) word, so variable bus latency stalls the whole pipeline cleanly.
- Sits between the control unit (pc, mem_in_use in; clk_enable, instruction out) and the instruction memory/bus.

Parameters:
- BUS_TIMEOUT, 255, WAIT-state cycles before fault is raised (0 disables the timeout).
- NOP_WORD, 32'h00000013, word driven after reset, on bubbles and on faults (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pc  in  30  word address from control unit; stable while clk_enable=0
- mem_in_use  in  1  data stage owns the bus this cycle; control unit holds pc
- ibus_req_valid  out  1  fetch request valid
- ibus_req_addr  out  30  fetch word address
- ibus_req_ready  in  1  bus accepts request
- ibus_resp_valid  in  1  response valid (never in the acceptance cycle)
- ibus_resp_data  in  32  instruction word
- clk_enable  out  1  pipeline advance strobe (combinational from state/inputs)
- instruction  out  32  registered instruction for the control unit (si stage)
- instruction_valid  out  1  registered; 0 marks a bubble
- fetch_fault  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; instruction=NOP_WORD; instruction_valid=0; fetch_fault=0; timeout counter=0.
  - While rst=1: ibus_req_valid=0 and clk_enable=0.
  - Any in-flight bus response after rst is ignored; the bus is reset with this block.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, mem_in_use=1:
    - clk_enable=1; no request.
    - instruction<=NOP_WORD, instruction_valid<=0 (bubble; control unit re-presents the same pc).
  - IDLE, mem_in_use=0:
    - ibus_req_valid=1, ibus_req_addr=pc; addr latched into req_addr_q.
    - ready=1 -> WAIT; ready=0 -> REQ. clk_enable=0.
  - REQ: ibus_req_valid=1, addr=req_addr_q held; ready=1 -> WAIT. mem_in_use is ignored once a request is pending.
  - WAIT, resp_valid=1:
    - clk_enable=1 in the same cycle.
    - instruction<=ibus_resp_data, instruction_valid<=1; -> IDLE.
  - WAIT, resp_valid=0: count cycles. If BUS_TIMEOUT!=0 and count reaches BUS_TIMEOUT:
    - fetch_fault<=1, clk_enable=1.
    - instruction<=NOP_WORD, valid<=0; -> IDLE.
- ibus_resp_valid outside WAIT is ignored.
- Latency:
  - Minimum 2 cycles per instruction: accept at N, respond at N+1, clk_enable at N+1.
  - Bubble costs 1 cycle.
- Counter is 8 bits, saturating; reset on entry to WAIT.
- instruction/instruction_valid change only on cycles with clk_enable=1 (or rst).
- Redirects and rewinds need no special handling: pc only changes after an enabled edge, and the next IDLE issues the new pc.

Optional Feature:
- Macro FETCH_REUSE_EN. When defined, adds a single-entry buffer of {tag_valid, tag_pc, word}.
  - Filled on every valid bus response; tag_valid cleared by rst and on fault.
  - In IDLE with mem_in_use=0, tag_valid=1 and pc==tag_pc: clk_enable=1, instruction<=word, valid<=1, no bus request (1-cycle delivery).
- Without the macro: every instruction goes through the bus; no buffer logic present.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_e enum (IDLE=2'b00, REQ=2'b01, WAIT=2'b10)
  - NOP_INSTR constant 32'h00000013
  - timeout counter width
- One natural sub-module: fetch_reuse_buffer (tag compare + storage), instantiated only under FETCH_REUSE_EN.

Test Plan:
- Reset: hold rst 3 cycles with resp_valid=1 -> instruction=0x00000013, valid=0, clk_enable=0, req_valid=0.
- Zero-wait bus: pc=0x10, ready=1, resp at next cycle with 0x00500093 -> clk_enable pulses once every 2 cycles; instruction=0x00500093, valid=1.
- Backpressure: ready low 3 cycles, pc changes illegally to 0x20 -> ibus_req_addr stays 0x10; resp 0xDEADBEEF delivered once.
- mem_in_use=1 in IDLE -> one clk_enable, instruction=NOP, valid=0, no ibus_req_valid.
- Timeout with BUS_TIMEOUT=4, no resp -> after 4 WAIT cycles fetch_fault=1 (sticky), NOP bubble, next request issued.
- FETCH_REUSE_EN: fetch pc=0x40, then mem_in_use bubble, pc still 0x40 -> delivered in 1 cycle with no bus request; after rst the same pc goes to the bus again.
